// File: rtl/mc_cpu_core.sv
// rtl/mc_cpu_core.sv - multi-cycle MIPS-style core with handshaked instruction and data ports
// One instruction at a time walks FETCH/DECODE/EXEC/(MEM)/(WB); HALT is left only via reset.
module mc_cpu_core #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int ADDR_W   = 12,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_valid,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              retire,
    output logic              halted,
    output logic              illegal,
    output logic [ADDR_W-1:0] pc,
    input  logic [4:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    localparam int RW = $clog2(NREGS);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LI   = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [31:0]         r_ir;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_result;
    logic [RW-1:0]       r_dest;
    logic [ADDR_W-1:0]   r_dmem_addr;
    logic                r_dmem_we;
    logic [DATA_W-1:0]   r_dmem_wdata;
    logic                r_retire;
    logic                r_illegal;
    logic [DATA_W-1:0]   r_regs [NREGS];

    logic [5:0]          w_op;
    logic [5:0]          w_funct;
    logic [4:0]          w_shamt;
    logic [15:0]         w_imm;
    logic [RW-1:0]       w_rs;
    logic [RW-1:0]       w_rt;
    logic [RW-1:0]       w_rd;
    logic [RW-1:0]       w_dbg_idx;
    logic [ADDR_W-1:0]   w_imm_a;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [ADDR_W-1:0]   w_pc_br;
    logic [ADDR_W-1:0]   w_ea;
    logic                w_br_taken;
    logic [DATA_W-1:0]   w_alu;
    logic [DATA_W-1:0]   w_result;
    logic                w_funct_ok;
    logic                w_legal;
    logic                w_retire;
    logic                w_illegal_set;
    logic                w_pc_we;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic                w_rf_we;

    assign w_op      = r_ir[31:26];
    assign w_funct   = r_ir[5:0];
    assign w_shamt   = r_ir[10:6];
    assign w_imm     = r_ir[15:0];
    assign w_rs      = r_ir[21 +: RW];
    assign w_rt      = r_ir[16 +: RW];
    assign w_rd      = r_ir[11 +: RW];
    assign w_dbg_idx = dbg_raddr[RW-1:0];

    // Offsets are sign-extended straight to the address width so every address wraps mod 2^ADDR_W.
    assign w_imm_a    = ADDR_W'($signed(w_imm));
    assign w_pc_inc   = r_pc + ADDR_W'(1);
    assign w_pc_br    = w_pc_inc + w_imm_a;
    assign w_ea       = r_a[ADDR_W-1:0] + w_imm_a;
    assign w_br_taken = (w_op == OP_BEQ) ? (r_a == r_b) : (r_a != r_b);

    always_comb begin
        w_alu      = '0;
        w_funct_ok = 1'b1;
        case (w_funct)
            F_ADD:   w_alu = r_a + r_b;
            F_SUB:   w_alu = r_a - r_b;
            F_AND:   w_alu = r_a & r_b;
            F_OR:    w_alu = r_a | r_b;
            F_XOR:   w_alu = r_a ^ r_b;
            F_SLT:   w_alu = DATA_W'($signed(r_a) < $signed(r_b));
            F_SLL:   w_alu = r_b << w_shamt;
            F_SRL:   w_alu = r_b >> w_shamt;
            default: w_funct_ok = 1'b0;
        endcase
    end

    assign w_result = (w_op == OP_LI) ? DATA_W'(w_imm) : w_alu;

    always_comb begin
        case (w_op)
            OP_R:                                        w_legal = w_funct_ok;
            OP_LI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_HALT: w_legal = 1'b1;
            default:                                     w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_retire      = 1'b0;
        w_illegal_set = 1'b0;
        w_pc_we       = 1'b0;
        w_pc_nxt      = w_pc_inc;
        w_rf_we       = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (imem_valid) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                if (!w_legal) begin
                    w_illegal_set = 1'b1;
                    w_next        = S_HALT;
                end else begin
                    case (w_op)
                        OP_LW, OP_SW: w_next = S_MEM;
                        OP_BEQ, OP_BNE: begin
                            w_pc_we  = 1'b1;
                            w_pc_nxt = w_br_taken ? w_pc_br : w_pc_inc;
                            w_retire = 1'b1;
                            w_next   = S_FETCH;
                        end
                        OP_J: begin
                            w_pc_we  = 1'b1;
                            w_pc_nxt = r_ir[ADDR_W-1:0];
                            w_retire = 1'b1;
                            w_next   = S_FETCH;
                        end
                        OP_HALT: begin
                            w_retire = 1'b1;
                            w_next   = S_HALT;
                        end
                        default: w_next = S_WB;
                    endcase
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (r_dmem_we) begin
                        w_pc_we  = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                w_rf_we  = 1'b1;
                w_pc_we  = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            default: w_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= ADDR_W'(RESET_PC);
            r_ir         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_result     <= '0;
            r_dest       <= '0;
            r_dmem_addr  <= '0;
            r_dmem_we    <= 1'b0;
            r_dmem_wdata <= '0;
            r_retire     <= 1'b0;
            r_illegal    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (r_state == S_FETCH && imem_valid) begin
                r_ir <= imem_rdata;
            end
            if (r_state == S_DECODE) begin
                r_a <= r_regs[w_rs];
                r_b <= r_regs[w_rt];
            end
            if (r_state == S_EXEC) begin
                r_result <= w_result;
                r_dest   <= (w_op == OP_R) ? w_rd : w_rt;
                if (w_op == OP_LW || w_op == OP_SW) begin
                    r_dmem_addr  <= w_ea;
                    r_dmem_we    <= (w_op == OP_SW);
                    r_dmem_wdata <= r_b;
                end
            end
            if (r_state == S_MEM && dmem_ready && !r_dmem_we) begin
                r_result <= dmem_rdata;
            end
            // r0 is never written, so it stays at its reset value of zero.
            if (w_rf_we && r_dest != '0) begin
                r_regs[r_dest] <= r_result;
            end
            if (w_pc_we) begin
                r_pc <= w_pc_nxt;
            end
            r_retire <= w_retire;
            if (w_illegal_set) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // FETCH is the reset state, so the fetch request is also masked by reset itself.
    assign imem_req   = (r_state == S_FETCH) && rst_n;
    assign imem_addr  = r_pc;
    assign dmem_req   = (r_state == S_MEM);
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign retire     = r_retire;
    assign halted     = (r_state == S_HALT);
    assign illegal    = r_illegal;
    assign pc         = r_pc;
    assign dbg_rdata  = (w_dbg_idx == '0) ? '0 : r_regs[w_dbg_idx];

endmodule

// File: tb/tb_mc_cpu_core.sv
// tb/tb_mc_cpu_core.sv - directed and randomized checks of mc_cpu_core against an ISA-level model
`timescale 1ns/1ps
module tb_mc_cpu_core;
    localparam int AW   = 12;
    localparam int MEMW = 4096;
    localparam logic [31:0] HALT_W = 32'hFC00_0000;
    localparam logic [5:0] FNS [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00, 6'h02};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          imem_req, imem_valid, dmem_req, dmem_we, dmem_ready, retire, halted, illegal;
    logic [AW-1:0] imem_addr, dmem_addr, pc;
    logic [31:0]   imem_rdata, dmem_wdata, dmem_rdata, dbg_rdata;
    logic [4:0]    dbg_raddr = '0;

    logic          d16_imem_req, d16_imem_valid, d16_dmem_req, d16_dmem_we, d16_dmem_ready;
    logic          d16_retire, d16_halted, d16_illegal;
    logic [AW-1:0] d16_imem_addr, d16_dmem_addr, d16_pc;
    logic [31:0]   d16_imem_rdata;
    logic [15:0]   d16_dmem_wdata, d16_dmem_rdata, d16_dbg_rdata;
    logic [4:0]    d16_dbg_raddr = '0;

    mc_cpu_core u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .retire(retire), .halted(halted), .illegal(illegal), .pc(pc),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    mc_cpu_core #(.DATA_W(16), .NREGS(8), .ADDR_W(AW), .RESET_PC(0)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(d16_imem_req), .imem_addr(d16_imem_addr), .imem_rdata(d16_imem_rdata),
        .imem_valid(d16_imem_valid),
        .dmem_req(d16_dmem_req), .dmem_we(d16_dmem_we), .dmem_addr(d16_dmem_addr),
        .dmem_wdata(d16_dmem_wdata), .dmem_rdata(d16_dmem_rdata), .dmem_ready(d16_dmem_ready),
        .retire(d16_retire), .halted(d16_halted), .illegal(d16_illegal), .pc(d16_pc),
        .dbg_raddr(d16_dbg_raddr), .dbg_rdata(d16_dbg_rdata)
    );

    logic [31:0] imem   [MEMW];
    logic [31:0] dmem   [MEMW];
    logic [31:0] imem16 [16];
    logic [31:0] m_mem  [MEMW];
    logic [31:0] m_reg  [32];
    logic [AW-1:0] m_pc;
    int m_cycles, m_retires;
    bit m_halted, m_illegal;

    int i_wait = 0, d_wait = 0;
    int retire_cnt, i_cnt, d_cnt;
    int st_hold;
    bit st_stable, d_stab;
    logic [AW-1:0] st_addr, d_a0;
    logic [31:0]   st_wdata, d_w0;
    logic          d_we0;

    int n_vec = 0, n_err = 0;

    // Memory responders: react to requests seen on the falling edge, with programmable wait states.
    initial begin
        imem_valid = 1'b0; imem_rdata = '0; dmem_ready = 1'b0; dmem_rdata = '0;
        d16_imem_valid = 1'b0; d16_imem_rdata = '0; d16_dmem_ready = 1'b1; d16_dmem_rdata = '0;
        retire_cnt = 0; i_cnt = 0; d_cnt = 0; st_hold = 0; st_stable = 1'b0; d_stab = 1'b0;
        st_addr = '0; st_wdata = '0; d_a0 = '0; d_w0 = '0; d_we0 = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) retire_cnt = 0;
            else if (retire) retire_cnt++;
            if (imem_req) begin
                i_cnt++;
                if (i_cnt > i_wait) begin
                    imem_valid = 1'b1; imem_rdata = imem[imem_addr];
                end else begin
                    imem_valid = 1'b0; imem_rdata = $urandom;
                end
            end else begin
                i_cnt = 0; imem_valid = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
            end
            if (dmem_req) begin
                if (d_cnt == 0) begin
                    d_a0 = dmem_addr; d_w0 = dmem_wdata; d_we0 = dmem_we; d_stab = 1'b1;
                end else if (dmem_addr !== d_a0 || dmem_wdata !== d_w0 || dmem_we !== d_we0) begin
                    d_stab = 1'b0;
                end
                d_cnt++;
                if (d_cnt > d_wait) begin
                    dmem_ready = 1'b1;
                    if (dmem_we) begin
                        dmem[dmem_addr] = dmem_wdata;
                        st_hold = d_cnt; st_stable = d_stab; st_addr = d_a0; st_wdata = d_w0;
                    end else begin
                        dmem_rdata = dmem[dmem_addr];
                    end
                end else begin
                    dmem_ready = 1'b0; dmem_rdata = $urandom;
                end
            end else begin
                d_cnt = 0; dmem_ready = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
            end
            d16_imem_valid = d16_imem_req;
            d16_imem_rdata = imem16[d16_imem_addr[3:0]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(int t);
        return {6'h02, 26'(t)};
    endfunction

    task automatic fill_halt();
        for (int i = 0; i < MEMW; i++) imem[i] = HALT_W;
    endtask

    task automatic init_mem(input bit rnd);
        logic [31:0] v;
        for (int i = 0; i < MEMW; i++) begin
            v = rnd ? $urandom : 32'h0;
            dmem[i] = v; m_mem[i] = v;
        end
    endtask

    task automatic dbg_rd(input int idx, output logic [31:0] v);
        dbg_raddr = 5'(idx);
        #1;
        v = dbg_rdata;
    endtask

    // Reference: instruction-set interpreter with a per-instruction cycle cost.
    function automatic void m_wr(logic [4:0] idx, logic [31:0] v);
        if (idx != 5'd0) m_reg[idx] = v;
    endfunction

    task automatic model_run(input int iw, input int dw);
        logic [31:0] ins, a, b, res, simm, ea;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh;
        bit ok;
        int n;
        m_cycles = 0; m_retires = 0; m_halted = 1'b0; m_illegal = 1'b0; n = 0;
        while (!m_halted && n < 500) begin
            ins = imem[m_pc]; n++;
            op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
            sh = ins[10:6];  fn = ins[5:0];
            a = m_reg[rs]; b = m_reg[rt];
            simm = {{16{ins[15]}}, ins[15:0]};
            ea = a + simm;
            ok = 1'b1; res = '0;
            case (op)
                6'h00: begin
                    case (fn)
                        6'h20: res = a + b;
                        6'h22: res = a - b;
                        6'h24: res = a & b;
                        6'h25: res = a | b;
                        6'h26: res = a ^ b;
                        6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        6'h00: res = b << sh;
                        6'h02: res = b >> sh;
                        default: ok = 1'b0;
                    endcase
                    if (ok) begin
                        m_wr(rd, res); m_pc = m_pc + 1'b1; m_cycles += 4 + iw; m_retires++;
                    end
                end
                6'h0F: begin
                    m_wr(rt, {16'h0, ins[15:0]}); m_pc = m_pc + 1'b1; m_cycles += 4 + iw; m_retires++;
                end
                6'h23: begin
                    m_wr(rt, m_mem[ea[11:0]]); m_pc = m_pc + 1'b1; m_cycles += 5 + iw + dw; m_retires++;
                end
                6'h2B: begin
                    m_mem[ea[11:0]] = b; m_pc = m_pc + 1'b1; m_cycles += 4 + iw + dw; m_retires++;
                end
                6'h04, 6'h05: begin
                    if ((op == 6'h04) == (a == b)) m_pc = m_pc + 1'b1 + simm[11:0];
                    else m_pc = m_pc + 1'b1;
                    m_cycles += 3 + iw; m_retires++;
                end
                6'h02: begin
                    m_pc = ins[11:0]; m_cycles += 3 + iw; m_retires++;
                end
                6'h3F: begin
                    m_halted = 1'b1; m_cycles += 3 + iw; m_retires++;
                end
                default: ok = 1'b0;
            endcase
            if (!ok) begin
                m_illegal = 1'b1; m_halted = 1'b1; m_cycles += 3 + iw;
            end
        end
    endtask

    task automatic start_run(input int iw, input int dw);
        i_wait = iw; d_wait = dw;
        @(posedge clk);
        #2 rst_n = 1'b0;
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_pc = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic run_until_halt(output int cyc);
        cyc = 0;
        while (!halted && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic compare_all(input string name, input int cyc);
        logic [31:0] v;
        int diffs;
        chk({name, "_halted"}, halted, 1'b1);
        chk({name, "_cycles"}, cyc, m_cycles);
        chk({name, "_retires"}, retire_cnt, m_retires);
        chk({name, "_pc"}, pc, m_pc);
        chk({name, "_illegal"}, illegal, m_illegal);
        for (int i = 0; i < 32; i++) begin
            dbg_rd(i, v);
            chk($sformatf("%s_r%0d", name, i), v, m_reg[i]);
        end
        diffs = 0;
        for (int i = 0; i < MEMW; i++) if (dmem[i] !== m_mem[i]) diffs++;
        chk({name, "_dmem_image"}, diffs, 0);
    endtask

    initial begin
        int cyc;
        int iw, dw;
        logic [31:0] v;

        for (int i = 0; i < 16; i++) imem16[i] = HALT_W;
        imem16[0] = enc_i(6'h0F, 0, 1, 16'd3);
        imem16[1] = enc_r(0, 1, 9, 15, 6'h00);

        @(posedge clk);
        #1;
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_dmem_req", dmem_req, 1'b0);
        chk("rst_dmem_bus", {dmem_we, dmem_addr, dmem_wdata}, '0);
        chk("rst_status", {retire, halted, illegal}, 3'b000);
        chk("rst_pc", pc, 0);

        // R-type sequence
        fill_halt(); init_mem(1'b0);
        imem[0] = enc_i(6'h0F, 0, 1, 16'd2);
        imem[1] = enc_i(6'h0F, 0, 2, 16'd1);
        imem[2] = enc_r(1, 2, 3, 0, 6'h20);
        imem[3] = enc_r(2, 1, 4, 0, 6'h22);
        start_run(0, 0);
        #1 chk("first_fetch_req", imem_req, 1'b1);
        model_run(0, 0);
        run_until_halt(cyc);
        chk("rtype_halt_cycle", cyc, 19);
        chk("rtype_retires", retire_cnt, 5);
        dbg_rd(3, v); chk("rtype_r3", v, 32'd3);
        dbg_rd(4, v); chk("rtype_r4", v, 32'hFFFF_FFFF);
        compare_all("rtype", cyc);

        // Load/store with data-port wait states
        fill_halt(); init_mem(1'b0);
        imem[0] = enc_i(6'h0F, 0, 1, 16'h0010);
        imem[1] = enc_i(6'h2B, 0, 1, 16'd4);
        imem[2] = enc_i(6'h23, 0, 5, 16'd4);
        start_run(0, 2);
        model_run(0, 2);
        run_until_halt(cyc);
        chk("sw_hold_cycles", st_hold, 3);
        chk("sw_stable", st_stable, 1'b1);
        chk("sw_addr", st_addr, 4);
        chk("sw_wdata", st_wdata, 32'h10);
        dbg_rd(5, v); chk("lw_r5", v, 32'h10);
        compare_all("ldst", cyc);

        // Taken beq loops on itself
        fill_halt(); init_mem(1'b0);
        imem[0] = enc_j(5);
        imem[5] = enc_i(6'h04, 0, 0, 16'hFFFF);
        start_run(0, 0);
        repeat (9) @(posedge clk);
        #1;
        chk("beq_loop_pc", pc, 5);
        chk("beq_loop_retires", retire_cnt + int'(retire), 3);
        chk("beq_loop_running", halted, 1'b0);

        // Untaken bne falls through
        imem[5] = enc_i(6'h05, 0, 0, 16'd3);
        start_run(0, 0);
        model_run(0, 0);
        run_until_halt(cyc);
        chk("bne_pc", pc, 6);
        compare_all("bne", cyc);

        // Backward branch wraps below zero
        fill_halt();
        imem[0] = enc_i(6'h04, 0, 0, 16'hFFFE);
        start_run(1, 0);
        model_run(1, 0);
        run_until_halt(cyc);
        chk("wrap_pc", pc, 12'hFFF);
        compare_all("wrap", cyc);

        // r0 write discarded, then illegal opcode
        fill_halt();
        imem[0] = enc_i(6'h0F, 0, 0, 16'd7);
        imem[1] = {6'h11, 26'h0};
        start_run(0, 0);
        model_run(0, 0);
        run_until_halt(cyc);
        dbg_rd(0, v); chk("r0_zero", v, 0);
        chk("illegal_flag", illegal, 1'b1);
        chk("illegal_halted", halted, 1'b1);
        chk("illegal_no_retire", retire_cnt, 1);
        compare_all("illegal", cyc);

        // Reset while a load waits on the data port
        fill_halt(); init_mem(1'b0);
        dmem[4] = 32'hABCD; m_mem[4] = 32'hABCD;
        imem[0] = enc_i(6'h23, 0, 5, 16'd4);
        start_run(0, 100000);
        cyc = 0;
        while (!dmem_req && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("midmem_reached", dmem_req, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midmem_dmem_req", dmem_req, 1'b0);
        chk("midmem_imem_req", imem_req, 1'b0);
        chk("midmem_pc", pc, 0);
        dbg_rd(5, v); chk("midmem_r5", v, 0);

        // Randomized programs with random wait states
        for (int k = 0; k < 10; k++) begin
            int kind;
            fill_halt(); init_mem(1'b1);
            for (int p = 0; p < 14; p++) begin
                kind = $urandom_range(0, 19);
                if (kind < 6)
                    imem[p] = enc_i(6'h0F, 0, $urandom_range(0, 7), 16'($urandom));
                else if (kind < 12)
                    imem[p] = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                                    $urandom_range(0, 31), FNS[$urandom_range(0, 7)]);
                else if (kind < 14)
                    imem[p] = enc_i(6'h23, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
                else if (kind < 16)
                    imem[p] = enc_i(6'h2B, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
                else if (kind < 18)
                    imem[p] = enc_i(($urandom_range(0, 1) != 0) ? 6'h05 : 6'h04, $urandom_range(0, 7),
                                    $urandom_range(0, 7), 16'($urandom_range(0, 2)));
                else if (kind < 19)
                    imem[p] = enc_j(p + int'($urandom_range(1, 3)));
                else if ($urandom_range(0, 3) == 0)
                    imem[p] = ($urandom_range(0, 1) != 0) ? {6'h11, 26'h0} : enc_r(1, 2, 3, 0, 6'h3F);
                else
                    imem[p] = enc_i(6'h0F, 0, $urandom_range(1, 7), 16'($urandom));
            end
            iw = $urandom_range(0, 2);
            dw = $urandom_range(0, 2);
            start_run(iw, dw);
            model_run(iw, dw);
            run_until_halt(cyc);
            compare_all($sformatf("rnd%0d", k), cyc);
        end

        // Narrow datapath / small register file instance
        start_run(0, 0);
        repeat (20) @(posedge clk);
        #1;
        d16_dbg_raddr = 5'd1;
        #1 chk("sweep_r1", d16_dbg_rdata, 16'h8000);
        d16_dbg_raddr = 5'd9;
        #1 chk("sweep_r9_alias", d16_dbg_rdata, 16'h8000);
        chk("sweep_halted", d16_halted, 1'b1);
        chk("sweep_illegal", d16_illegal, 1'b0);
        chk("sweep_pc", d16_pc, 2);
        chk("sweep_idle", {d16_dmem_req, d16_dmem_we, d16_dmem_addr, d16_dmem_wdata, d16_retire}, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
